vga_fb_scanout: RTL and testbench
=================================

VGA_FB_SCANOUT -- requirements
Module: vga_fb_scanout

Interface
REQ-001 SHALL have ports: in_clock  in  1  system clock, 50 MHz; all logic on rising edge.
REQ-002 SHALL have port: in_reset  in  1  synchronous, active-high reset.
REQ-003 SHALL have port: in_strobe  in  1  pixel enable, 25 MHz, high one clock in two.
REQ-004 SHALL have ports: in_x  in  10  pixel column; in_y  in  9  pixel row; both from the timing generator, valid on strobe cycles.
REQ-005 SHALL have ports: in_hsync  in  1 and in_vsync  in  1  raw syncs from the timing generator.
REQ-006 SHALL have ports: in_wr_valid  in  1; in_wr_addr  in  15; in_wr_data  in  4  palette index; out_wr_ready  out  1.
REQ-007 SHALL have ports: in_pal_we  in  1; in_pal_idx  in  4; in_pal_rgb  in  12  {R,G,B} 4 bits each.
REQ-008 SHALL have ports: out_red, out_green, out_blue  out  4 each; out_hsync, out_vsync  out  1 each.

Function
REQ-009 Framebuffer SHALL hold 160x120 entries, 4-bit palette indices, linear address = row*160 + col; each entry covers a 4x4 block of the 640x480 screen.
REQ-010 Scan pipeline SHALL advance only on in_strobe; stage 1 registers addr = (in_y>>2)*160 + (in_x>>2), computed by shift-add (128+32), plus active = (in_x<640)&(in_y<480).
REQ-011 Stage 2 SHALL perform the synchronous RAM read on the clock after the stage-1 strobe (the read cycle).
REQ-012 Stage 3 SHALL look up the 16-entry palette and register the RGB outputs; total latency is 3 strobes from in_x/in_y to out_red/green/blue.
REQ-013 in_hsync/in_vsync SHALL be delayed by exactly 3 strobes so they stay aligned with the RGB outputs.
REQ-014 RGB outputs SHALL be 0 whenever the delayed active flag is 0.
REQ-015 Write handshake: a transfer occurs when in_wr_valid & out_wr_ready on a clock edge; data is captured into a one-entry pending register.
REQ-016 out_wr_ready SHALL be 1 exactly when the pending register is empty (registered, no combinational path from in_wr_valid).
REQ-017 Pending write SHALL commit to RAM on the first clock that is not a read cycle, clearing pending; reads always take priority.
REQ-018 A write with in_wr_addr >= 19200 SHALL be accepted and discarded, with no RAM change.
REQ-019 When a write and a read hit the same address, the read SHALL return the old data; the new data is visible on the next read.
REQ-020 Palette write (in_pal_we) SHALL take effect on that clock edge; a stage-3 lookup on the same edge uses the old entry.
REQ-021 in_wr_valid with out_wr_ready=0 SHALL be ignored; the source holds the data until it is accepted.

Reset
REQ-022 On in_reset: RGB outputs 0, out_hsync=out_vsync=1, sync delay chain all 1, active flags 0, pending cleared, out_wr_ready=1 on the following cycle.
REQ-023 On in_reset the palette SHALL load grey ramp: entry i = {i,i,i}.
REQ-024 Framebuffer RAM contents SHALL NOT be reset; reset mid-frame SHALL drop in-flight pixels and any pending write.

Structure
REQ-025 Shared package vga_fb_pkg SHALL define FB_W=160, FB_H=120, FB_DEPTH=19200, FB_AW=15, SCALE_SHIFT=2, H_ACTIVE=640, V_ACTIVE=480, PIPE_LAT=3.
REQ-026 RAM SHALL be a sub-module fb_ram: single-port, 19200x4, synchronous read and write, no reset, suitable for block RAM inference.
REQ-027 Palette, pipeline, sync delay and write arbitration SHALL live in vga_fb_scanout itself.

Verification
REQ-028 Write addr 0 data 5 and pal[5]=0xF00; drive x=0,y=0 on strobe -> 3 strobes later RGB=F,0,0.
REQ-029 Write addr 161 data 3; scan x=4..7,y=4..7 -> all 16 pixels show pal[3]; x=8,y=4 shows entry 162.
REQ-030 Hold in_wr_valid continuously during scan -> exactly one commit per non-read cycle, none on read cycles, no lost or duplicated writes.
REQ-031 Write addr 19200 data 7 -> accepted (ready drops 1 cycle), RAM addresses 0..19199 unchanged.
REQ-032 Scan x=640 or y=480 -> RGB=0; hsync pulse at input reappears on out_hsync exactly 3 strobes later.
REQ-033 Assert in_reset mid-line with a write pending -> next cycle RGB=0, syncs=1, pending dropped, pal[9] reads 0x999.

Source files
------------

// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the 160x120 palette framebuffer scanout.
package vga_fb_pkg;

    localparam int FB_W        = 160;
    localparam int FB_H        = 120;
    localparam int FB_DEPTH    = 19200;
    localparam int FB_AW       = 15;
    localparam int SCALE_SHIFT = 2;
    localparam int H_ACTIVE    = 640;
    localparam int V_ACTIVE    = 480;
    localparam int PIPE_LAT    = 3;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } rgb_t;

    typedef struct packed {
        logic             valid;
        logic [FB_AW-1:0] addr;
        logic [3:0]       data;
    } wr_req_t;

    // Screen pixel to framebuffer word: (y/4)*160 + x/4, with *160 done as *128 + *32.
    function automatic logic [FB_AW-1:0] fb_addr(input logic [9:0] x, input logic [8:0] y);
        logic [FB_AW-1:0] row;
        logic [FB_AW-1:0] col;
        row = FB_AW'(y >> SCALE_SHIFT);
        col = FB_AW'(x >> SCALE_SHIFT);
        return (row << 7) + (row << 5) + col;
    endfunction

endpackage

// File: rtl/fb_ram.sv
// Single-port 19200x4 framebuffer RAM, synchronous read and write.
module fb_ram
    import vga_fb_pkg::*;
(
    input  logic             in_clock,
    input  logic             in_we,
    input  logic             in_re,
    input  logic [FB_AW-1:0] in_addr,
    input  logic [3:0]       in_wdata,
    output logic [3:0]       out_rdata
);

    logic [3:0] mem [0:FB_DEPTH-1];

    // Write port and registered read port sharing one address.
    // NOTE: the array and read register carry no reset so this maps onto block RAM.
    always_ff @(posedge in_clock) begin
        if (in_we) begin
            mem[in_addr] <= in_wdata;
        end
        if (in_re) begin
            out_rdata <= mem[in_addr];
        end
    end

endmodule

// File: rtl/vga_fb_scanout.sv
// Framebuffer scanout: 3-strobe pixel pipeline (address, RAM read, palette),
// sync delay, write arbitration into the RAM and a 16-entry palette.
module vga_fb_scanout
    import vga_fb_pkg::*;
(
    input  logic             in_clock,
    input  logic             in_reset,
    input  logic             in_strobe,
    input  logic [9:0]       in_x,
    input  logic [8:0]       in_y,
    input  logic             in_hsync,
    input  logic             in_vsync,
    input  logic             in_wr_valid,
    input  logic [FB_AW-1:0] in_wr_addr,
    input  logic [3:0]       in_wr_data,
    output logic             out_wr_ready,
    input  logic             in_pal_we,
    input  logic [3:0]       in_pal_idx,
    input  logic [11:0]      in_pal_rgb,
    output logic [3:0]       out_red,
    output logic [3:0]       out_green,
    output logic [3:0]       out_blue,
    output logic             out_hsync,
    output logic             out_vsync
);

    logic [FB_AW-1:0]    s1_addr;
    logic                s1_active;
    logic [3:0]          s2_idx;
    logic                s2_active;
    logic                rd_cycle;
    logic [PIPE_LAT-1:0] hs_dly;
    logic [PIPE_LAT-1:0] vs_dly;
    rgb_t                pal [0:15];
    rgb_t                rgb_q;
    wr_req_t             pend;

    logic                commit;
    logic                ram_we;
    logic                ram_re;
    logic [FB_AW-1:0]    ram_addr;
    logic [3:0]          ram_rdata;

    // Pipeline data words; only the active flags need a reset to blank the output.
    // NOTE: data registers are left unreset; the reset active flags already mask them.
    always_ff @(posedge in_clock) begin
        if (in_strobe) begin
            s1_addr <= fb_addr(in_x, in_y);
            s2_idx  <= ram_rdata;
        end
    end

    // Active flags and sync delay chain, advancing one step per strobe.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            s1_active <= 1'b0;
            s2_active <= 1'b0;
            hs_dly    <= '1;
            vs_dly    <= '1;
        end else if (in_strobe) begin
            s1_active <= (in_x < 10'(H_ACTIVE)) && (in_y < 9'(V_ACTIVE));
            s2_active <= s1_active;
            hs_dly    <= {hs_dly[PIPE_LAT-2:0], in_hsync};
            vs_dly    <= {vs_dly[PIPE_LAT-2:0], in_vsync};
        end
    end

    // The clock right after a strobe owns the RAM for the pixel read.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            rd_cycle <= 1'b0;
        end else begin
            rd_cycle <= in_strobe;
        end
    end

    assign out_wr_ready = !pend.valid;
    assign commit       = pend.valid && !rd_cycle;

    // One-entry pending write: accept when empty, drain on the first non-read clock.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            pend.valid <= 1'b0;
        end else if (commit) begin
            pend.valid <= 1'b0;
        end else if (in_wr_valid && !pend.valid) begin
            pend.valid <= 1'b1;
            pend.addr  <= in_wr_addr;
            pend.data  <= in_wr_data;
        end
    end

    // Out-of-range writes still drain the pending slot but never reach the RAM.
    assign ram_re   = rd_cycle;
    assign ram_we   = commit && (pend.addr < FB_AW'(FB_DEPTH));
    assign ram_addr = rd_cycle ? s1_addr : pend.addr;

    fb_ram u_fb_ram (
        .in_clock  (in_clock),
        .in_we     (ram_we),
        .in_re     (ram_re),
        .in_addr   (ram_addr),
        .in_wdata  (pend.data),
        .out_rdata (ram_rdata)
    );

    // Palette storage and stage-3 lookup with blanking outside the active area.
    // NOTE: non-blocking updates mean a lookup on the write edge still sees the old entry.
    always_ff @(posedge in_clock) begin
        if (in_reset) begin
            for (int i = 0; i < 16; i++) begin
                pal[i] <= {4'(i), 4'(i), 4'(i)};
            end
            rgb_q <= '0;
        end else begin
            if (in_pal_we) begin
                pal[in_pal_idx] <= in_pal_rgb;
            end
            if (in_strobe) begin
                rgb_q <= s2_active ? pal[s2_idx] : '0;
            end
        end
    end

    assign out_red   = rgb_q.r;
    assign out_green = rgb_q.g;
    assign out_blue  = rgb_q.b;
    assign out_hsync = hs_dly[PIPE_LAT-1];
    assign out_vsync = vs_dly[PIPE_LAT-1];

endmodule

// File: tb/tb_vga_fb_scanout.sv
// Directed self-checking bench for vga_fb_scanout.
module tb_vga_fb_scanout;

    logic        in_clock;
    logic        in_reset;
    logic        in_strobe;
    logic [9:0]  in_x;
    logic [8:0]  in_y;
    logic        in_hsync;
    logic        in_vsync;
    logic        in_wr_valid;
    logic [14:0] in_wr_addr;
    logic [3:0]  in_wr_data;
    logic        out_wr_ready;
    logic        in_pal_we;
    logic [3:0]  in_pal_idx;
    logic [11:0] in_pal_rgb;
    logic [3:0]  out_red;
    logic [3:0]  out_green;
    logic [3:0]  out_blue;
    logic        out_hsync;
    logic        out_vsync;

    vga_fb_scanout dut (
        .in_clock     (in_clock),
        .in_reset     (in_reset),
        .in_strobe    (in_strobe),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_hsync     (in_hsync),
        .in_vsync     (in_vsync),
        .in_wr_valid  (in_wr_valid),
        .in_wr_addr   (in_wr_addr),
        .in_wr_data   (in_wr_data),
        .out_wr_ready (out_wr_ready),
        .in_pal_we    (in_pal_we),
        .in_pal_idx   (in_pal_idx),
        .in_pal_rgb   (in_pal_rgb),
        .out_red      (out_red),
        .out_green    (out_green),
        .out_blue     (out_blue),
        .out_hsync    (out_hsync),
        .out_vsync    (out_vsync)
    );

    initial in_clock = 1'b0;
    always #10 in_clock = ~in_clock;

    int cyc_cnt = 0;
    always @(posedge in_clock) cyc_cnt <= cyc_cnt + 1;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [11:0] rgb;
        logic [1:0]  sync;
    } exp_t;

    exp_t        q[$];
    logic [11:0] pal_model [16];
    logic [3:0]  fb_model  [19200];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic grey_palette();
        for (int i = 0; i < 16; i++) begin
            pal_model[i] = {4'(i), 4'(i), 4'(i)};
        end
    endtask

    // One pixel: strobe clock then idle clock. Output after this pixel's strobe
    // edge belongs to the pixel pushed two calls earlier.
    task automatic push(input int x, input int y, input logic hs, input logic vs);
        exp_t e;
        bit   act;
        int   a;
        act = (x < 640) && (y < 480);
        a   = (y / 4) * 160 + (x / 4);
        e.rgb  = act ? pal_model[fb_model[a]] : 12'h000;
        e.sync = {hs, vs};
        q.push_back(e);
        in_strobe = 1'b1;
        in_x      = 10'(x);
        in_y      = 9'(y);
        in_hsync  = hs;
        in_vsync  = vs;
        @(posedge in_clock);
        #1;
        in_strobe = 1'b0;
        @(posedge in_clock);
        #1;
        if (q.size() == 3) begin
            e = q.pop_front();
            check($sformatf("pix_rgb x=%0d y=%0d", x, y), 32'({out_red, out_green, out_blue}), 32'(e.rgb));
            check($sformatf("pix_sync x=%0d y=%0d", x, y), 32'({out_hsync, out_vsync}), 32'(e.sync));
        end
    endtask

    task automatic drain();
        push(700, 500, 1'b1, 1'b1);
        push(700, 500, 1'b1, 1'b1);
    endtask

    // Idle-time write: wait for ready, transfer, then ready low one clock.
    task automatic wr(input int addr, input int data);
        int t;
        t = 0;
        in_wr_addr  = 15'(addr);
        in_wr_data  = 4'(data);
        in_wr_valid = 1'b1;
        while (!out_wr_ready && t < 40) begin
            @(posedge in_clock);
            #1;
            t++;
        end
        check("wr_ready_wait", 32'(t < 40), 32'd1);
        @(posedge in_clock);
        #1;
        in_wr_valid = 1'b0;
        check("wr_ready_low", 32'(out_wr_ready), 32'd0);
        @(posedge in_clock);
        #1;
        check("wr_ready_back", 32'(out_wr_ready), 32'd1);
        if (addr < 19200) fb_model[addr] = 4'(data);
    endtask

    task automatic pal_wr(input int idx, input logic [11:0] rgb);
        in_pal_we  = 1'b1;
        in_pal_idx = 4'(idx);
        in_pal_rgb = rgb;
        @(posedge in_clock);
        #1;
        in_pal_we = 1'b0;
        pal_model[idx] = rgb;
    endtask

    int acc_cnt;
    int first_acc;
    int last_acc;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_reset    = 1'b1;
        in_strobe   = 1'b0;
        in_x        = '0;
        in_y        = '0;
        in_hsync    = 1'b1;
        in_vsync    = 1'b1;
        in_wr_valid = 1'b0;
        in_wr_addr  = '0;
        in_wr_data  = '0;
        in_pal_we   = 1'b0;
        in_pal_idx  = '0;
        in_pal_rgb  = '0;
        for (int i = 0; i < 19200; i++) fb_model[i] = 4'h0;
        grey_palette();

        repeat (3) @(posedge in_clock);
        #1;
        in_reset = 1'b0;
        check("reset_rgb", 32'({out_red, out_green, out_blue}), 32'h000);
        check("reset_sync", 32'({out_hsync, out_vsync}), 32'b11);
        check("reset_ready", 32'(out_wr_ready), 32'd1);

        // Basic pixel: entry 0 -> palette 5 = pure red.
        wr(0, 5);
        pal_wr(5, 12'hF00);
        q.delete();
        push(0, 0, 1'b0, 1'b1);
        push(1, 0, 1'b1, 1'b1);
        drain();

        // 4x4 block replication plus neighbouring block.
        wr(161, 3);
        wr(162, 9);
        wr(160, 6);
        pal_wr(3, 12'h5A3);
        q.delete();
        for (int y = 4; y < 8; y++) begin
            for (int x = 4; x < 8; x++) begin
                push(x, y, logic'((x + y) % 3 != 0), logic'(y != 5));
            end
        end
        push(8, 4, 1'b1, 1'b1);
        // Outside the active area: blanked even though the RAM word is non-zero.
        push(640, 0, 1'b0, 1'b1);
        push(0, 480, 1'b1, 1'b0);
        push(700, 500, 1'b0, 1'b0);
        drain();

        // Writes held valid while scanning: reads keep priority, writes keep flowing.
        for (int j = 0; j < 8; j++) wr(320 + j, j + 1);
        acc_cnt   = 0;
        first_acc = -1;
        last_acc  = -1;
        q.delete();
        fork
            begin
                for (int x = 0; x < 32; x++) push(x, 8, 1'b1, 1'b1);
                drain();
            end
            begin
                in_wr_valid = 1'b1;
                for (int i = 0; i < 16; i++) begin
                    int t;
                    t = 0;
                    in_wr_addr = 15'(400 + i);
                    in_wr_data = 4'(i);
                    while (!out_wr_ready && t < 40) begin
                        @(posedge in_clock);
                        #1;
                        t++;
                    end
                    if (t < 40) begin
                        @(posedge in_clock);
                        #1;
                        acc_cnt++;
                        if (first_acc < 0) first_acc = cyc_cnt;
                        last_acc = cyc_cnt;
                        fb_model[400 + i] = 4'(i);
                    end
                end
                in_wr_valid = 1'b0;
            end
        join
        check("burst_count", 32'(acc_cnt), 32'd16);
        check("burst_span", 32'((last_acc - first_acc) <= 31), 32'd1);
        q.delete();
        for (int i = 0; i < 16; i++) push(320 + 4 * i, 8, 1'b1, 1'b1);
        drain();

        // Out-of-range write is swallowed without touching any RAM word.
        wr(2816, 10);
        wr(19199, 12);
        wr(19200, 7);
        q.delete();
        push(0, 0, 1'b1, 1'b1);
        push(384, 68, 1'b1, 1'b1);
        push(636, 476, 1'b1, 1'b1);
        push(4, 4, 1'b1, 1'b1);
        drain();

        // Reset mid-line with pixels in flight and a write pending.
        q.delete();
        push(0, 0, 1'b0, 1'b0);
        push(0, 0, 1'b0, 1'b0);
        push(0, 0, 1'b0, 1'b0);
        in_strobe   = 1'b1;
        in_wr_valid = 1'b1;
        in_wr_addr  = 15'd0;
        in_wr_data  = 4'hE;
        @(posedge in_clock);
        #1;
        check("pend_before_reset", 32'(out_wr_ready), 32'd0);
        in_wr_valid = 1'b0;
        in_strobe   = 1'b0;
        in_reset    = 1'b1;
        @(posedge in_clock);
        #1;
        in_reset = 1'b0;
        in_hsync = 1'b1;
        in_vsync = 1'b1;
        check("midreset_rgb", 32'({out_red, out_green, out_blue}), 32'h000);
        check("midreset_sync", 32'({out_hsync, out_vsync}), 32'b11);
        check("midreset_ready", 32'(out_wr_ready), 32'd1);
        grey_palette();
        q.delete();
        push(0, 0, 1'b1, 1'b1);
        push(8, 4, 1'b1, 1'b1);
        push(4, 4, 1'b1, 1'b1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
